// File: rtl/comparator_bist_pkg.sv
// Shared constants and state encoding for the comparator self-test block.
package comparator_bist_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_ERR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : comparator_bist_pkg

// File: rtl/comparator_bist_golden.sv
// Reference magnitude comparator: unsigned a vs b as {eq, gt, lt}.
module comparator_bist_golden #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       golden_c
);

    assign golden_c = {a == b, a > b, a < b};

endmodule : comparator_bist_golden

// File: rtl/comparator_bist.sv
// Sweeps every operand pair into an external comparator and checks its eq/gt/lt response.
module comparator_bist
    import comparator_bist_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ERR_W = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic             eq_in,
    input  logic             gt_in,
    input  logic             lt_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b
);

    localparam int unsigned IDX_W = 2 * WIDTH;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [WIDTH-1:0]   ffa_q, ffa_d;
    logic [WIDTH-1:0]   ffb_q, ffb_d;
    logic               fail_seen_q, fail_seen_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic [2:0]         golden_c;
    logic               mismatch_c;

    // Golden model sees the registered operands, which are stable throughout CHECK.
    comparator_bist_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .a        (a_q),
        .b        (b_q),
        .golden_c (golden_c)
    );

    // Any response other than the exact golden pattern (including non-one-hot) is a failure.
    assign mismatch_c = (golden_c != {eq_in, gt_in, lt_in});

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        err_d       = err_q;
        ffa_d       = ffa_q;
        ffb_d       = ffb_q;
        fail_seen_d = fail_seen_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d       = '0;
                    ffa_d       = '0;
                    ffb_d       = '0;
                    fail_seen_d = 1'b0;
                    idx_d       = '0;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                a_d     = idx_q[IDX_W-1:WIDTH];
                b_d     = idx_q[WIDTH-1:0];
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fail_seen_q) begin
                        ffa_d       = a_q;
                        ffb_d       = b_q;
                        fail_seen_d = 1'b1;
                    end
                end
                if (idx_q == {IDX_W{1'b1}}) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            err_q       <= '0;
            ffa_q       <= '0;
            ffb_q       <= '0;
            fail_seen_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            err_q       <= err_d;
            ffa_q       <= ffa_d;
            ffb_q       <= ffb_d;
            fail_seen_q <= fail_seen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign err_count    = err_q;
    assign first_fail_a = ffa_q;
    assign first_fail_b = ffb_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;

endmodule : comparator_bist

// File: tb/tb_comparator_bist.sv
// Directed bench: drives comparator_bist against a 4-bit comparator with selectable faults.
module tb_comparator_bist;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned ERR_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             eq_in;
    logic             gt_in;
    logic             lt_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] first_fail_a;
    logic [WIDTH-1:0] first_fail_b;

    // 0 = correct, 1 = eq stuck-at-0, 2 = gt/lt swapped, 3 = all outputs 0
    int unsigned mode;
    int unsigned n_checks;
    int unsigned n_fail;

    comparator_bist #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a_out        (a_out),
        .b_out        (b_out),
        .eq_in        (eq_in),
        .gt_in        (gt_in),
        .lt_in        (lt_in),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .first_fail_a (first_fail_a),
        .first_fail_b (first_fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator standing in for the device under test, with injectable faults.
    always_comb begin
        eq_in = (a_out == b_out);
        gt_in = (a_out > b_out);
        lt_in = (a_out < b_out);
        case (mode)
            1: eq_in = 1'b0;
            2: begin
                gt_in = (a_out < b_out);
                lt_in = (a_out > b_out);
            end
            3: begin
                eq_in = 1'b0;
                gt_in = 1'b0;
                lt_in = 1'b0;
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Accept a start, then count edges until done; optionally poke start while busy.
    task automatic run_sweep(input bit poke_busy, output int unsigned cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (poke_busy && cycles == 50) start = 1'b1;
            if (poke_busy && cycles == 51) start = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass), 32'd0);
        check_eq({tag, "_err"}, 32'(err_count), 32'd0);
        check_eq({tag, "_a"}, 32'(a_out), 32'd0);
        check_eq({tag, "_b"}, 32'(b_out), 32'd0);
        check_eq({tag, "_ffa"}, 32'(first_fail_a), 32'd0);
        check_eq({tag, "_ffb"}, 32'(first_fail_b), 32'd0);
    endtask

    initial begin
        int unsigned cyc;
        n_checks = 0;
        n_fail   = 0;
        mode     = 0;
        start    = 1'b0;
        rst_n    = 1'b0;
        #23;
        check_all_zero("rst");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_done", 32'(done), 32'd0);

        // Clean sweep, with a start pulse mid-sweep that must be ignored.
        run_sweep(1'b1, cyc);
        check_eq("clean_cycles", cyc, 32'd512);
        check_eq("clean_pass", 32'(pass), 32'd1);
        check_eq("clean_err", 32'(err_count), 32'd0);
        check_eq("clean_busy", 32'(busy), 32'd0);
        check_eq("clean_last_a", 32'(a_out), 32'd15);
        check_eq("clean_last_b", 32'(b_out), 32'd15);
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_hold", 32'(done), 32'd1);

        // eq stuck-at-0, restarted straight from DONE.
        mode = 1;
        run_sweep(1'b0, cyc);
        check_eq("eq0_cycles", cyc, 32'd512);
        check_eq("eq0_err", 32'(err_count), 32'd16);
        check_eq("eq0_ffa", 32'(first_fail_a), 32'd0);
        check_eq("eq0_ffb", 32'(first_fail_b), 32'd0);
        check_eq("eq0_pass", 32'(pass), 32'd0);
        check_eq("eq0_done", 32'(done), 32'd1);

        // Restart from DONE: err_count clears on the accept edge.
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("restart_err_clr", 32'(err_count), 32'd0);
        check_eq("restart_busy", 32'(busy), 32'd1);
        check_eq("restart_done", 32'(done), 32'd0);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("swap_cycles", cyc, 32'd512);
        check_eq("swap_err", 32'(err_count), 32'd240);
        check_eq("swap_ffa", 32'(first_fail_a), 32'd0);
        check_eq("swap_ffb", 32'(first_fail_b), 32'd1);
        check_eq("swap_pass", 32'(pass), 32'd0);

        // All-zero response saturates the 8-bit counter.
        mode = 3;
        run_sweep(1'b0, cyc);
        check_eq("zero_cycles", cyc, 32'd512);
        check_eq("zero_err_sat", 32'(err_count), 32'd255);
        check_eq("zero_ffa", 32'(first_fail_a), 32'd0);
        check_eq("zero_ffb", 32'(first_fail_b), 32'd0);
        check_eq("zero_pass", 32'(pass), 32'd0);

        // Reset during pair 100 with errors accumulating; outputs clear before the next edge.
        mode = 3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (201) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_eq("mid_a", 32'(a_out), 32'd6);
        check_eq("mid_b", 32'(b_out), 32'd4);
        rst_n = 1'b0;
        #2;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        run_sweep(1'b0, cyc);
        check_eq("post_rst_cycles", cyc, 32'd512);
        check_eq("post_rst_pass", 32'(pass), 32'd1);
        check_eq("post_rst_err", 32'(err_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_comparator_bist
